// File: rtl/usbserial_line_buffer.sv
// Line-editing echo stage for the USB CDC byte stream.
// Collects received bytes into a line buffer with backspace handling, then
// echoes the finished line (optionally upper-cased) followed by CR LF.
module usbserial_line_buffer #(
  parameter int DEPTH     = 64,
  parameter bit UPPERCASE = 1'b1
) (
  input  logic        clk_48mhz,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] line_count,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEN_FULL = LW'(DEPTH);

  typedef enum logic [2:0] {
    ST_FILL = 3'd0,
    ST_PREP = 3'd1,
    ST_ECHO = 3'd2,
    ST_CR   = 3'd3,
    ST_LF   = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [LW-1:0] len_r, len_s;
  logic [LW-1:0] rd_idx_r, rd_idx_s;
  logic          prev_cr_r, prev_cr_s;
  logic [7:0]    out_data_r, out_data_s;
  logic [15:0]   line_count_r, line_count_s;
  logic          overflow_r, overflow_s;
  logic          in_ready_r, out_valid_r;
  logic          wr_en_s;
  logic [7:0]    mem_q_r;
  logic          accept_s, xfer_s;

  logic [7:0] mem [0:DEPTH-1];

  // Echo transform: optional lower-to-upper case mapping of ASCII letters.
  function automatic logic [7:0] xform(input logic [7:0] b);
    logic [7:0] r;
    if (UPPERCASE && (b >= 8'h61) && (b <= 8'h7A)) begin
      r = b - 8'h20;
    end else begin
      r = b;
    end
    return r;
  endfunction

  assign accept_s   = in_valid & in_ready_r;
  assign xfer_s     = out_valid_r & out_ready;
  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign line_count = line_count_r;
  assign overflow   = overflow_r;

  // Next-state and datapath decisions for the line editor.
  always_comb begin
    state_s      = state_r;
    len_s        = len_r;
    rd_idx_s     = rd_idx_r;
    prev_cr_s    = prev_cr_r;
    out_data_s   = out_data_r;
    line_count_s = line_count_r;
    overflow_s   = 1'b0;
    wr_en_s      = 1'b0;
    case (state_r)
      ST_FILL: begin
        if (accept_s) begin
          if (in_data == 8'h0D) begin
            prev_cr_s = 1'b1;
            state_s   = ST_PREP;
          end else if (in_data == 8'h0A) begin
            // LF right after CR is the second half of a CRLF pair: swallow it.
            if (prev_cr_r) begin
              prev_cr_s = 1'b0;
            end else begin
              prev_cr_s = 1'b0;
              state_s   = ST_PREP;
            end
          end else if ((in_data == 8'h08) || (in_data == 8'h7F)) begin
            prev_cr_s = 1'b0;
            if (len_r != '0) begin
              len_s = len_r - LW'(1);
            end else begin
              len_s = len_r;
            end
          end else begin
            wr_en_s   = 1'b1;
            prev_cr_s = 1'b0;
            len_s     = len_r + LW'(1);
            if ((len_r + LW'(1)) == LEN_FULL) begin
              overflow_s = 1'b1;
              state_s    = ST_PREP;
            end else begin
              state_s = ST_FILL;
            end
          end
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_PREP: begin
        // mem_q_r already holds buf[0]: the read address was 0 while filling.
        if (len_r == '0) begin
          out_data_s = 8'h0D;
          state_s    = ST_CR;
        end else begin
          out_data_s = xform(mem_q_r);
          rd_idx_s   = LW'(1);
          state_s    = ST_ECHO;
        end
      end
      ST_ECHO: begin
        // mem_q_r tracks buf[rd_idx] so the next byte is ready on every transfer.
        if (xfer_s) begin
          if (rd_idx_r == len_r) begin
            out_data_s = 8'h0D;
            state_s    = ST_CR;
          end else begin
            out_data_s = xform(mem_q_r);
            rd_idx_s   = rd_idx_r + LW'(1);
          end
        end else begin
          state_s = ST_ECHO;
        end
      end
      ST_CR: begin
        if (xfer_s) begin
          out_data_s = 8'h0A;
          state_s    = ST_LF;
        end else begin
          state_s = ST_CR;
        end
      end
      ST_LF: begin
        if (xfer_s) begin
          len_s        = '0;
          rd_idx_s     = '0;
          line_count_s = line_count_r + 16'd1;
          state_s      = ST_FILL;
        end else begin
          state_s = ST_LF;
        end
      end
      default: begin
        state_s  = ST_FILL;
        len_s    = '0;
        rd_idx_s = '0;
      end
    endcase
  end

  // Control and output registers; handshake flags decoded from next state.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state_r      <= ST_FILL;
      len_r        <= '0;
      rd_idx_r     <= '0;
      prev_cr_r    <= 1'b0;
      out_data_r   <= 8'h00;
      line_count_r <= 16'd0;
      overflow_r   <= 1'b0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      len_r        <= len_s;
      rd_idx_r     <= rd_idx_s;
      prev_cr_r    <= prev_cr_s;
      out_data_r   <= out_data_s;
      line_count_r <= line_count_s;
      overflow_r   <= overflow_s;
      in_ready_r   <= (state_s == ST_FILL);
      out_valid_r  <= (state_s == ST_ECHO) || (state_s == ST_CR) || (state_s == ST_LF);
    end
  end

  // Line buffer: write on store, synchronous read at the upcoming rd_idx.
  always_ff @(posedge clk_48mhz) begin
    if (wr_en_s) begin
      mem[len_r[AW-1:0]] <= in_data;
    end
    mem_q_r <= mem[rd_idx_s[AW-1:0]];
  end

endmodule

// File: tb/tb_usbserial_line_buffer.sv
// Self-checking bench for usbserial_line_buffer (DEPTH=4, UPPERCASE=1).
module tb_usbserial_line_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] line_count;
  logic        overflow;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int ovf_seen = 0;
  bit rand_mode = 1'b0;

  // Reference model state
  byte         m_line[$];
  byte         exp_q[$];
  bit          m_prev_cr;
  int          exp_lines;
  bit          exp_ovf;
  bit          held;
  logic [7:0]  held_data;

  // Observed output log, for literal checks
  byte         act_log[$];
  int          act_cyc[$];

  usbserial_line_buffer #(.DEPTH(DEPTH), .UPPERCASE(1'b1)) dut (
    .clk_48mhz (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .line_count(line_count),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic byte upcase(input byte b);
    if (b >= 8'h61 && b <= 8'h7A) return byte'(b - 8'h20);
    return b;
  endfunction

  task automatic flush_line();
    foreach (m_line[i]) exp_q.push_back(upcase(m_line[i]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    m_line.delete();
  endtask

  // Line-editing rules applied to one accepted byte.
  task automatic model_accept(input byte b);
    if (b == 8'h0D) begin
      flush_line();
      m_prev_cr = 1'b1;
    end else if (b == 8'h0A) begin
      if (m_prev_cr) m_prev_cr = 1'b0;
      else flush_line();
    end else if (b == 8'h08 || b == 8'h7F) begin
      if (m_line.size() > 0) void'(m_line.pop_back());
      m_prev_cr = 1'b0;
    end else begin
      m_line.push_back(b);
      m_prev_cr = 1'b0;
      if (m_line.size() == DEPTH) begin
        flush_line();
        exp_ovf = 1'b1;
      end
    end
  endtask

  // Per-cycle compare against the model, sampled on the inactive edge.
  always @(negedge clk) begin
    if (reset) begin
      m_line.delete();
      exp_q.delete();
      m_prev_cr = 1'b0;
      exp_lines = 0;
      exp_ovf   = 1'b0;
      held      = 1'b0;
    end else begin
      cyc++;
      chk("line_count", line_count, exp_lines);
      chk("overflow", overflow, exp_ovf);
      chk("ready_valid_excl", in_ready & out_valid, 0);
      if (overflow) ovf_seen++;
      if (held) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held_data);
      end
      exp_ovf = 1'b0;
      if (out_valid && out_ready) begin
        act_log.push_back(out_data);
        act_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_out", out_data, 32'hFFFF_FFFF);
        end else begin
          byte e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e);
          if (e == 8'h0A) exp_lines++;
        end
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      if (in_valid && in_ready) model_accept(in_data);
    end
  end

  // Downstream ready: constant high or random, changed away from the edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  task automatic send_byte(input byte b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && in_ready && !out_valid) break;
      n++;
      if (n > 500) begin
        chk("idle_timeout", exp_q.size(), 0);
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name, input string exp);
    chk({name, "_len"}, act_log.size(), exp.len());
    for (int i = 0; i < exp.len() && i < act_log.size(); i++)
      chk(name, act_log[i], exp[i]);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_line_count", line_count, 0);
    chk("rst_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    act_log.delete();
    act_cyc.delete();
    ovf_seen = 0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    #2;
    do_reset();

    // abc CR at full throughput
    send_str("abc");
    send_byte(8'h0D);
    wait_idle();
    check_log("abc", "ABC\015\012");
    if (act_cyc.size() == 5) chk("abc_consecutive", act_cyc[4] - act_cyc[0], 4);
    else chk("abc_count", act_cyc.size(), 5);
    chk("abc_lines", line_count, 1);

    // CRLF pair does not create an empty line
    do_reset();
    send_str("hi");
    send_byte(8'h0D);
    send_byte(8'h0A);
    send_str("x");
    send_byte(8'h0D);
    wait_idle();
    check_log("crlf", "HI\015\012X\015\012");
    chk("crlf_lines", line_count, 2);

    // Backspace and delete, extra ones at empty line ignored
    do_reset();
    send_str("ab");
    send_byte(8'h08);
    send_str("c");
    send_byte(8'h7F);
    send_byte(8'h7F);
    send_byte(8'h7F);
    send_str("d");
    send_byte(8'h0D);
    wait_idle();
    check_log("bksp", "D\015\012");
    chk("bksp_lines", line_count, 1);

    // Overflow at DEPTH=4
    do_reset();
    send_str("abcdef");
    send_byte(8'h0D);
    wait_idle();
    check_log("ovf", "ABCD\015\012EF\015\012");
    chk("ovf_pulses", ovf_seen, 1);
    chk("ovf_lines", line_count, 2);

    // Full line followed by CR gives an empty line
    do_reset();
    send_str("wxyz");
    send_byte(8'h0D);
    wait_idle();
    check_log("ovf_empty", "WXYZ\015\012\015\012");
    chk("ovf_empty_lines", line_count, 2);

    // Random downstream stalls
    do_reset();
    rand_mode = 1'b1;
    send_str("hello");
    send_byte(8'h0D);
    wait_idle();
    rand_mode = 1'b0;
    check_log("stall", "HELL\015\012O\015\012");
    chk("stall_lines", line_count, 2);

    // Reset in the middle of an echo
    do_reset();
    send_str("abc");
    send_byte(8'h0D);
    n = 0;
    while (act_log.size() < 1 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("mid_first_byte", act_log.size(), 1);
    #2;
    do_reset();
    send_str("z");
    send_byte(8'h0D);
    wait_idle();
    check_log("after_rst", "Z\015\012");
    chk("after_rst_lines", line_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
